// File: rtl/osc_meter_pkg.sv
// ---------------------------------------------------------------------------
// osc_meter_pkg
// Shared definitions for the oscillator frequency meter: the measurement
// state encoding, the synchroniser depth and a helper that locates one
// channel's count inside the packed count bus.
// ---------------------------------------------------------------------------
package osc_meter_pkg;

  // Measurement sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    GATE  = 2'd2,
    LATCH = 2'd3
  } meterState_t;

  // Flops in the metastability synchroniser ahead of the edge detector
  localparam int SYNC_STAGES = 2;

  // Lowest bit of channel 'ch' inside a packed bus of 'width'-bit slices
  function automatic int chanLsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/osc_edge_sync.sv
// ---------------------------------------------------------------------------
// osc_edge_sync
// Brings one asynchronous oscillator bit into the clk domain and turns each
// rising edge into a single-cycle registered pulse.  A rise on i_osc shows up
// on o_edge three clk edges later.
//
// Ports:
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   i_osc   in   raw oscillator bit, asynchronous to clk
//   o_edge  out  one-cycle pulse per detected rising edge
// ---------------------------------------------------------------------------
module osc_edge_sync
  import osc_meter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_osc,
  output logic o_edge
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_edge;

  // Synchroniser chain, delayed copy of its output and the registered
  // rising-edge pulse; runs every cycle regardless of what the meter is doing
  // so that no stale edge is reported when a window opens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_edge <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_osc};
      r_prev <= r_sync[SYNC_STAGES-1];
      r_edge <= r_sync[SYNC_STAGES-1] & ~r_prev;
    end
  end

  assign o_edge = r_edge;

endmodule

// File: rtl/osc_freq_meter_hyst.sv
// ---------------------------------------------------------------------------
// osc_freq_meter_hyst
// Counts rising edges of N_CH asynchronous oscillators over a gate window of
// gate_len clk cycles, one-shot or back-to-back, with saturating counters,
// per-channel overflow flags and a hysteresis over-temperature warning.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   en         in   block enable; low aborts any measurement in progress
//   osc_in     in   raw oscillator outputs (N_CH bits)
//   start      in   one-shot trigger, only looked at while idle
//   cont       in   continuous back-to-back measurements
//   gate_len   in   window length in clk cycles, 0 behaves as 1
//   thr_hi     in   warning set threshold (count must exceed it)
//   thr_lo     in   warning clear threshold (count must fall below it)
//   count_out  out  latched counts, channel i at [i*CNT_W +: CNT_W]
//   ovf        out  channel saturated during the last window
//   warn       out  hysteresis warning per channel
//   valid      out  one-cycle pulse when count_out/ovf/warn update
//   busy       out  measurement in progress (CLEAR, GATE, LATCH)
// ---------------------------------------------------------------------------
module osc_freq_meter_hyst
  import osc_meter_pkg::*;
#(
  parameter int N_CH   = 2,
  parameter int CNT_W  = 16,
  parameter int GATE_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [N_CH-1:0]         osc_in,
  input  logic                    start,
  input  logic                    cont,
  input  logic [GATE_W-1:0]       gate_len,
  input  logic [CNT_W-1:0]        thr_hi,
  input  logic [CNT_W-1:0]        thr_lo,
  output logic [N_CH*CNT_W-1:0]   count_out,
  output logic [N_CH-1:0]         ovf,
  output logic [N_CH-1:0]         warn,
  output logic                    valid,
  output logic                    busy
);

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [GATE_W-1:0] GATE_ONE = GATE_W'(1);

  meterState_t             r_state;
  logic [GATE_W-1:0]       r_timer;
  logic [GATE_W-1:0]       r_gateLen;
  logic [CNT_W-1:0]        r_cnt [N_CH];
  logic [N_CH-1:0]         r_sat;
  logic [N_CH*CNT_W-1:0]   r_countOut;
  logic [N_CH-1:0]         r_ovf;
  logic [N_CH-1:0]         r_warn;
  logic                    r_valid;
  logic                    r_busy;

  logic [N_CH-1:0]         w_edge;
  logic [CNT_W-1:0]        w_cntNext [N_CH];
  logic [N_CH-1:0]         w_satNext;

  // One synchroniser/edge detector per oscillator channel
  for (genvar g = 0; g < N_CH; g++) begin : g_sync
    osc_edge_sync u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_osc  (osc_in[g]),
      .o_edge (w_edge[g])
    );
  end

  // Counter values after this cycle's edge pulses.  The counter sticks at
  // its maximum and any further edge raises the saturation flag instead.
  // These are also what gets latched at the end of the window, so an edge
  // in the final gate cycle still makes it into count_out.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      w_cntNext[i] = r_cnt[i];
      w_satNext[i] = r_sat[i];
      if (w_edge[i]) begin
        if (r_cnt[i] == CNT_MAX) begin
          w_satNext[i] = 1'b1;
        end else begin
          w_cntNext[i] = r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Measurement sequencer: IDLE -> CLEAR -> GATE (gate_len cycles) -> LATCH,
  // looping back to CLEAR while continuous mode is on.  Dropping en sends it
  // to IDLE from anywhere without touching the reported results.  The result
  // registers, warning hysteresis and the valid strobe are all loaded on the
  // GATE -> LATCH edge so valid is high exactly during LATCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_timer    <= '0;
      r_gateLen  <= '0;
      r_sat      <= '0;
      r_countOut <= '0;
      r_ovf      <= '0;
      r_warn     <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_valid <= 1'b0;
      if (!en) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start || cont) begin
              r_state <= CLEAR;
              r_busy  <= 1'b1;
            end
          end
          CLEAR: begin
            r_timer   <= '0;
            r_gateLen <= (gate_len == '0) ? GATE_ONE : gate_len;
            r_sat     <= '0;
            for (int i = 0; i < N_CH; i++) begin
              r_cnt[i] <= '0;
            end
            r_state <= GATE;
          end
          GATE: begin
            r_sat <= w_satNext;
            for (int i = 0; i < N_CH; i++) begin
              r_cnt[i] <= w_cntNext[i];
            end
            if (r_timer == r_gateLen - GATE_ONE) begin
              r_state <= LATCH;
              r_valid <= 1'b1;
              r_ovf   <= w_satNext;
              for (int i = 0; i < N_CH; i++) begin
                r_countOut[chanLsb(i, CNT_W) +: CNT_W] <= w_cntNext[i];
                if (!r_warn[i] && (w_cntNext[i] > thr_hi)) begin
                  r_warn[i] <= 1'b1;
                end else if (r_warn[i] && (w_cntNext[i] < thr_lo)) begin
                  r_warn[i] <= 1'b0;
                end
              end
            end else begin
              r_timer <= r_timer + GATE_ONE;
            end
          end
          LATCH: begin
            if (cont) begin
              r_state <= CLEAR;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign count_out = r_countOut;
  assign ovf       = r_ovf;
  assign warn      = r_warn;
  assign valid     = r_valid;
  assign busy      = r_busy;

endmodule
